// File: rtl/amiga_target_pkg.sv
// amiga_target_pkg: register map, STATUS bit positions and responder FSM states
// shared by the Amiga-side bus responder files.
package amiga_target_pkg;
    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_DATA   = 3'd1;
    localparam int ST_RX_VALID   = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_TX_COUNT   = 2;
    localparam int ST_RX_OVERRUN = 5;
    typedef enum logic [2:0] {
        TGT_STATE_IDLE,
        TGT_STATE_DECODE,
        TGT_STATE_WAIT_SPACE,
        TGT_STATE_ACK,
        TGT_STATE_RELEASE,
        TGT_STATE_BERR
    } tgt_state_t;
endpackage

// File: rtl/amiga_target_fifo.sv
// amiga_target_fifo: synchronous FIFO with occupancy count; pop is ignored when
// empty and the writer guarantees no push while full.
module amiga_target_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 4
) (
    input  logic                     sys_clk,
    input  logic                     n_reset,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_pop;
    assign empty  = count == '0;
    assign full   = count == (AW+1)'(DEPTH);
    assign do_pop = pop && !empty;
    assign rdata  = mem[rp];
    always_ff @(posedge sys_clk) begin
        if (push) mem[wp] <= wdata;
    end
    always_ff @(posedge sys_clk or negedge n_reset) begin
        if (!n_reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= push ? wp + AW'(1) : wp;
            rp    <= do_pop ? rp + AW'(1) : rp;
            count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/amiga_target_port.sv
// amiga_target_port: 68000 bus responder for a 16-byte window; Amiga writes feed
// a TX FIFO for the Pi, reads return STATUS or the Pi-loaded RX holding word.
module amiga_target_port
    import amiga_target_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR  = 24'hE9_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          TIMEOUT    = 2048
) (
    input  logic                          sys_clk,
    input  logic                          n_reset,
    input  logic                          enable,
    input  logic                          n_as,
    input  logic                          n_uds,
    input  logic                          n_lds,
    input  logic                          rnw,
    input  logic [22:0]                   a_in,
    input  logic [2:0]                    fc_in,
    input  logic [15:0]                   d_in,
    output logic [15:0]                   d_out,
    output logic                          d_oe,
    output logic                          n_dtack_out,
    output logic                          dtack_oe,
    output logic                          berr_oe,
    output logic [17:0]                   tx_data,
    output logic                          tx_valid,
    input  logic                          tx_pop,
    input  logic [15:0]                   rx_data,
    input  logic                          rx_load,
    output logic [$clog2(FIFO_DEPTH):0]   tx_count
);
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [1:0]    as_q, uds_q, lds_q, rnw_q;
    logic          as_s, uds_s, lds_s, rnw_s, ds_s, hit;
    tgt_state_t    state, next_state;
    logic [2:0]    reg_sel;
    logic [WW-1:0] wait_cnt;
    logic          acc, push, pop_rx, status_rd, tx_full, tx_empty;
    logic          rx_valid, rx_overrun;
    logic [15:0]   rx_hold, status, read_word;
    assign as_s  = as_q[1];
    assign uds_s = uds_q[1];
    assign lds_s = lds_q[1];
    assign rnw_s = rnw_q[1];
    assign ds_s  = !uds_s || !lds_s;
    assign hit   = !as_s && enable && fc_in != 3'b111 && a_in[22:3] == BASE_ADDR[23:4];
    always_comb begin
        next_state = state;
        acc        = 1'b0;
        case (state)
            TGT_STATE_IDLE:   next_state = hit ? TGT_STATE_DECODE : TGT_STATE_IDLE;
            TGT_STATE_DECODE: begin
                if (as_s) next_state = TGT_STATE_IDLE;
                else if (ds_s) begin
                    if (!rnw_s && reg_sel == REG_DATA && tx_full) next_state = TGT_STATE_WAIT_SPACE;
                    else begin
                        next_state = TGT_STATE_ACK;
                        acc        = 1'b1;
                    end
                end
            end
            TGT_STATE_WAIT_SPACE: begin
                if (as_s) next_state = TGT_STATE_IDLE;
                else if (!tx_full) begin
                    next_state = TGT_STATE_ACK;
                    acc        = 1'b1;
                end else if (wait_cnt == WW'(TIMEOUT - 1)) next_state = TGT_STATE_BERR;
            end
            TGT_STATE_ACK:    next_state = as_s ? TGT_STATE_RELEASE : TGT_STATE_ACK;
            TGT_STATE_BERR:   next_state = as_s ? TGT_STATE_IDLE : TGT_STATE_BERR;
            default:          next_state = TGT_STATE_IDLE;
        endcase
    end
    // Side effects fire only on the transition into ACK, so each fires once per cycle.
    assign push      = acc && !rnw_s && reg_sel == REG_DATA;
    assign pop_rx    = acc && rnw_s && reg_sel == REG_DATA;
    assign status_rd = acc && rnw_s && reg_sel == REG_STATUS;
    always_comb begin
        status                            = '0;
        status[ST_RX_VALID]               = rx_valid;
        status[ST_TX_FULL]                = tx_full;
        status[ST_TX_COUNT +: 3]          = 3'(tx_count);
        status[ST_RX_OVERRUN]             = rx_overrun;
        read_word = status_rd ? status : (pop_rx && rx_valid) ? rx_hold : 16'h0000;
    end
    assign dtack_oe    = state == TGT_STATE_ACK || state == TGT_STATE_RELEASE;
    assign n_dtack_out = state != TGT_STATE_ACK;
    assign d_oe        = state == TGT_STATE_ACK && rnw_s;
    assign berr_oe     = state == TGT_STATE_BERR;
    assign tx_valid    = !tx_empty;
    always_ff @(posedge sys_clk or negedge n_reset) begin
        if (!n_reset) begin
            as_q       <= 2'b11;
            uds_q      <= 2'b11;
            lds_q      <= 2'b11;
            rnw_q      <= 2'b11;
            state      <= TGT_STATE_IDLE;
            reg_sel    <= '0;
            wait_cnt   <= '0;
            d_out      <= '0;
            rx_hold    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            as_q       <= {as_q[0], n_as};
            uds_q      <= {uds_q[0], n_uds};
            lds_q      <= {lds_q[0], n_lds};
            rnw_q      <= {rnw_q[0], rnw};
            state      <= next_state;
            reg_sel    <= state == TGT_STATE_IDLE ? a_in[2:0] : reg_sel;
            wait_cnt   <= state == TGT_STATE_WAIT_SPACE ? wait_cnt + WW'(1) : '0;
            d_out      <= (acc && rnw_s) ? read_word : d_out;
            rx_hold    <= rx_load ? rx_data : rx_hold;
            rx_valid   <= rx_load || (rx_valid && !pop_rx);
            rx_overrun <= (rx_load && rx_valid) || (rx_overrun && !status_rd);
        end
    end
    amiga_target_fifo #(.W(18), .DEPTH(FIFO_DEPTH)) u_fifo (
        .sys_clk (sys_clk),
        .n_reset (n_reset),
        .push    (push),
        .wdata   ({!uds_s, !lds_s, d_in}),
        .pop     (tx_pop),
        .rdata   (tx_data),
        .empty   (tx_empty),
        .full    (tx_full),
        .count   (tx_count)
    );
endmodule
